control_unit_seq: RTL and testbench
===================================

# control_unit_seq

Parametrised multi-cycle control sequencer: fetches instructions from an external instruction memory over a req/ack handshake, holds them in an instruction register, decodes them into datapath controls and maintains the program counter. Adds a FETCH/EXEC/HALT state machine, relative conditional branches, register-indirect jump and a halt instruction. Sits between the instruction memory and the register-file/ALU datapath. Uses the same field layout and control signals as the current single-cycle control unit.

## Interface
- `RA_W`, 2: register address field width; `INST_W` = 7 + 3*RA_W (13 at default)
- `DATA_W`, 4: datapath word width (constant output, jump operand)
- `PC_W`, 4: program counter / instruction address width
- `CLK` in 1: clock, rising edge
- `RST` in 1: one clock; reset is synchronous and active-high
- `imem_req` out 1: fetch request
- `imem_addr` out PC_W: fetch address, equals `pc`
- `imem_ack` in 1: fetch data valid this cycle
- `imem_data` in INST_W: instruction word
- `aData` in DATA_W: register A read data (jump target)
- `Z`, `N` in 1: datapath zero/negative status of the A operand
- `DA`, `AA`, `BA` out RA_W: destination / A / B register addresses
- `muxB` out 1: 1 selects constant as B operand
- `FS` out 4: ALU function select
- `muxD` out 1: 1 selects memory data for write-back
- `RW`, `MW` out 1: register-write / memory-write strobes
- `constant` out DATA_W: SB field zero-extended
- `pc` out PC_W; `ir` out INST_W; `exec_valid` out 1 (high in EXEC); `halted` out 1

## Operation
- Instruction fields: op = ir[INST_W-1 -: 7], DR = next RA_W bits, SA, then SB = ir[RA_W-1:0]. DA=DR, AA=SA, BA=SB always.
- Decode by op[6:4]; cls 000 ALU-reg: RW=1, muxB=0, muxD=0, FS=op[3:0]. cls 100 ALU-imm: as 000 with muxB=1. cls 001 LD: RW=1, muxD=1, FS=0000. cls 010 ST: MW=1, muxB=0, FS=0000. cls 110 BR: low 0000 = BZ (taken if Z), 0001 = BN (taken if N), FS=0000. cls 111 low 0000 = JMP. cls 011 low 0000 = HALT. cls 101 low 0000 = NOP. Any other low nibble in 110/111/011/101 is illegal.
- RW and MW are gated by EXEC; outside EXEC they are 0. Other decode outputs are combinational from `ir` at all times.
- FSM states:
  - FETCH: `imem_req`=1. On `imem_ack`, `ir`<=`imem_data` and the FSM moves to EXEC. Otherwise it stays in FETCH.
  - EXEC: exactly one cycle. PC update and next state:
    - default: `pc`<=`pc`+1
    - taken branch: `pc`<=`pc`+sext({DR,SB}), an offset of 2*RA_W bits, relative to the branch's own address
    - JMP: `pc`<=aData[PC_W-1:0], or zero-extended when DATA_W<PC_W
    - HALT: `pc` is unchanged and the next state is HALT; all others go to FETCH.
  - HALT: `halted`=1, no requests, all strobes 0. The FSM leaves HALT only on `RST`.
- PC arithmetic is modulo 2^PC_W and wraps silently.
- `Z`/`N` are sampled in the EXEC cycle of the branch.

## Timing
- Reset values: state FETCH, `pc`=0, `ir`=0, `halted`=0, RW=MW=0, `exec_valid`=0. `imem_req`=1 on the first cycle after reset.
- Minimum of 2 cycles per instruction: ack in the first FETCH cycle, then EXEC. Each cycle of ack delay adds one cycle.
- `imem_ack` is ignored outside FETCH and in any cycle where `RST`=1.
- `RST` has priority over all transitions. Reset asserted mid-fetch or in EXEC suppresses that cycle's PC update; no strobe is issued in the reset cycle.
- `imem_addr` is stable for the whole FETCH state.

## Configuration
- `CU_TRAP_EN` defined:
  - An illegal opcode in EXEC goes to HALT with `pc` unchanged.
  - Adds an output `trap` (1 bit, reset 0) that is set with `halted` and cleared only by `RST`.
  - RW and MW are forced 0 for the illegal instruction.
- `CU_TRAP_EN` undefined: an illegal opcode executes as NOP (`pc`+1, no strobes), and the `trap` port is absent.

## Test plan
- Reset, then ack immediately with 13'b0000101_01_10_11 -> cycle 1 `imem_addr`=0, `imem_req`=1; EXEC: FS=0101, DA=1, AA=2, BA=3, RW=1, MW=0; next FETCH `pc`=1.
- ALU-imm 13'b1000010_00_00_11 with ack after 3-cycle delay -> FETCH held 3 cycles, then EXEC: muxB=1, `constant`=4'b0011.
- At `pc`=5, BZ with {DR,SB}=4'b1110 (-2): Z=1 -> `pc`=3; repeat with Z=0 -> `pc`=6. At `pc`=15, NOP -> `pc`=0 (wrap).
- JMP with aData=4'hA -> next `imem_addr`=10. HALT -> `halted`=1, `imem_req` stays 0 for 20 cycles, `pc` frozen; `RST` -> `pc`=0, FETCH.
- Opcode 7'b1100111 (illegal) -> with `CU_TRAP_EN`: `halted`=1, `trap`=1, RW=MW=0; without: `pc`+1, continue fetching.
- `RST` asserted in the EXEC cycle of ST -> MW stays 0, `pc`=0 next cycle, `imem_req`=1.

Source files
------------

// File: rtl/control_unit_seq.sv
// control_unit_seq: multi-cycle FETCH/EXEC/HALT sequencer that fetches, decodes and sequences the PC.
// Define CU_TRAP_EN to halt on illegal opcodes and expose the trap output.
module control_unit_seq #(
    parameter int RA_W   = 2,
    parameter int DATA_W = 4,
    parameter int PC_W   = 4,
    localparam int INST_W = 7 + 3*RA_W
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    input  logic [DATA_W-1:0] aData,
    input  logic              Z,
    input  logic              N,
    output logic [RA_W-1:0]   DA,
    output logic [RA_W-1:0]   AA,
    output logic [RA_W-1:0]   BA,
    output logic              muxB,
    output logic [3:0]        FS,
    output logic              muxD,
    output logic              RW,
    output logic              MW,
    output logic [DATA_W-1:0] constant,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] ir,
    output logic              exec_valid,
    output logic              halted
`ifdef CU_TRAP_EN
    , output logic            trap
`endif
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    state_t state, state_n;
    logic [PC_W-1:0] pc_n;
    logic [INST_W-1:0] ir_n;
    logic [6:0] op;
    logic [2:0] cls;
    logic [3:0] lo;
    logic [2*RA_W-1:0] off;
    logic alu, rw_dec, mw_dec, taken, is_jmp, is_halt, illegal;

    assign op  = ir[INST_W-1 -: 7];
    assign cls = op[6:4];
    assign lo  = op[3:0];
    assign DA  = ir[3*RA_W-1 -: RA_W];
    assign AA  = ir[2*RA_W-1 -: RA_W];
    assign BA  = ir[RA_W-1:0];
    assign off = {DA, BA};
    assign constant = DATA_W'(BA);

    assign alu     = (cls == 3'b000) || (cls == 3'b100);
    assign rw_dec  = alu || (cls == 3'b001);
    assign mw_dec  = (cls == 3'b010);
    assign muxB    = (cls == 3'b100);
    assign muxD    = (cls == 3'b001);
    assign FS      = alu ? lo : 4'b0000;
    assign taken   = (cls == 3'b110) && ((lo == 4'd0 && Z) || (lo == 4'd1 && N));
    assign is_jmp  = (cls == 3'b111) && (lo == 4'd0);
    assign is_halt = (cls == 3'b011) && (lo == 4'd0);
    assign illegal = ((cls == 3'b110) && (lo > 4'd1)) ||
                     ((cls == 3'b111 || cls == 3'b011 || cls == 3'b101) && (lo != 4'd0));

    assign exec_valid = (state == EXEC);
    assign halted     = (state == HALT);
    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    // Strobes fire only in a real EXEC cycle, never while reset is being applied
    assign RW = exec_valid && !RST && rw_dec;
    assign MW = exec_valid && !RST && mw_dec;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        if (state == FETCH && imem_ack) begin
            ir_n    = imem_data;
            state_n = EXEC;
        end
        if (state == EXEC) begin
            state_n = is_halt ? HALT : FETCH;
            pc_n    = is_halt ? pc :
                      is_jmp  ? PC_W'(aData) :
                      taken   ? pc + PC_W'($signed(off)) :
                                pc + PC_W'(1);
`ifdef CU_TRAP_EN
            if (illegal) begin
                state_n = HALT;
                pc_n    = pc;
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
        end
    end

`ifdef CU_TRAP_EN
    always_ff @(posedge CLK) begin
        if (RST)
            trap <= 1'b0;
        else if (exec_valid && illegal)
            trap <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_control_unit_seq.sv
// tb_control_unit_seq: directed self-checking bench for control_unit_seq.
module tb_control_unit_seq;
    logic        CLK = 0, RST = 1;
    logic        imem_req, imem_ack = 0;
    logic [3:0]  imem_addr, aData = 0, constant, pc, FS;
    logic [12:0] imem_data = 0, ir;
    logic        Z = 0, N = 0;
    logic [1:0]  DA, AA, BA;
    logic        muxB, muxD, RW, MW, exec_valid, halted;
`ifdef CU_TRAP_EN
    logic        trap;
`endif
    int tests = 0, fails = 0;

    localparam logic [12:0] NOP = 13'b1010000_00_00_00;

    control_unit_seq dut (
        .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .aData(aData), .Z(Z), .N(N),
        .DA(DA), .AA(AA), .BA(BA), .muxB(muxB), .FS(FS), .muxD(muxD), .RW(RW), .MW(MW),
        .constant(constant), .pc(pc), .ir(ir), .exec_valid(exec_valid), .halted(halted)
`ifdef CU_TRAP_EN
        , .trap(trap)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1;
        tick();
        RST = 0;
    endtask

    // Holds FETCH for 'delay' cycles, then acks 'inst'; returns sampled in EXEC
    task automatic fetch(input logic [12:0] inst, input int delay);
        logic [3:0] a0;
        a0 = imem_addr;
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("fetch_hold_req", imem_req, 1);
            chk("fetch_hold_addr", imem_addr, a0);
        end
        imem_ack = 1;
        imem_data = inst;
        tick();
        imem_ack = 0;
        chk("exec_valid", exec_valid, 1);
    endtask

    initial begin
        tick();
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_halted", halted, 0);
        chk("rst_rw", RW, 0);
        chk("rst_mw", MW, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, 0);

        fetch(13'b0000101_01_10_11, 0);
        chk("alu_fs", FS, 4'b0101);
        chk("alu_da", DA, 1);
        chk("alu_aa", AA, 2);
        chk("alu_ba", BA, 3);
        chk("alu_rw", RW, 1);
        chk("alu_mw", MW, 0);
        chk("alu_muxb", muxB, 0);
        tick();
        chk("alu_pc", pc, 1);
        chk("alu_next_req", imem_req, 1);

        fetch(13'b1000010_00_00_11, 3);
        chk("imm_muxb", muxB, 1);
        chk("imm_const", constant, 4'b0011);
        chk("imm_fs", FS, 4'b0010);
        chk("imm_rw", RW, 1);
        tick();
        chk("imm_pc", pc, 2);

        for (int i = 0; i < 3; i++) begin fetch(NOP, 0); chk("nop_rw", RW, 0); tick(); end
        chk("pre_bz_pc", pc, 5);
        fetch(13'b1100000_11_00_10, 0);
        Z = 1;
        chk("bz_fs", FS, 0);
        chk("bz_rw", RW, 0);
        tick();
        Z = 0;
        chk("bz_taken_pc", pc, 3);
        for (int i = 0; i < 2; i++) begin fetch(NOP, 0); tick(); end
        fetch(13'b1100000_11_00_10, 1);
        tick();
        chk("bz_not_taken_pc", pc, 6);
        fetch(13'b1100001_00_00_11, 0);
        N = 1;
        tick();
        N = 0;
        chk("bn_taken_pc", pc, 9);

        fetch(13'b1110000_00_01_00, 0);
        aData = 4'hF;
        chk("jmp_aa", AA, 1);
        tick();
        chk("jmp_addr", imem_addr, 15);
        fetch(NOP, 0);
        tick();
        chk("wrap_pc", pc, 0);

        fetch(13'b1100111_00_00_00, 0);
        chk("ill_rw", RW, 0);
        chk("ill_mw", MW, 0);
        tick();
`ifdef CU_TRAP_EN
        chk("ill_halted", halted, 1);
        chk("ill_trap", trap, 1);
        chk("ill_pc", pc, 0);
        chk("ill_req", imem_req, 0);
`else
        chk("ill_halted", halted, 0);
        chk("ill_pc", pc, 1);
        chk("ill_req", imem_req, 1);
`endif
        do_reset();
        chk("rst2_pc", pc, 0);
`ifdef CU_TRAP_EN
        chk("rst2_trap", trap, 0);
`endif

        fetch(13'b0010000_10_01_00, 0);
        chk("ld_muxd", muxD, 1);
        chk("ld_rw", RW, 1);
        chk("ld_fs", FS, 0);
        tick();
        chk("ld_pc", pc, 1);
        fetch(13'b0100000_00_01_10, 0);
        chk("st_mw", MW, 1);
        chk("st_rw", RW, 0);
        RST = 1;
        #1;
        chk("st_rst_mw", MW, 0);
        tick();
        RST = 0;
        chk("st_rst_pc", pc, 0);
        chk("st_rst_req", imem_req, 1);
        chk("st_rst_exec", exec_valid, 0);

        fetch(13'b1110000_00_00_00, 2);
        aData = 4'hA;
        tick();
        chk("jmpa_addr", imem_addr, 10);
        fetch(13'b0110000_00_00_00, 0);
        tick();
        chk("halt_halted", halted, 1);
        imem_ack = 1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_req", imem_req, 0);
            chk("halt_pc", pc, 10);
            chk("halt_rw", RW, 0);
            tick();
        end
        imem_ack = 0;
        do_reset();
        chk("halt_rst_pc", pc, 0);
        chk("halt_rst_req", imem_req, 1);
        chk("halt_rst_halted", halted, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
